// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op and state encodings for the iterative multiply/divide unit
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        MulOp, MulhOp, MulhsuOp, MulhuOp, DivOp, DivuOp, RemOp, RemuOp
    } MulDiv_Ops;

    typedef enum logic [1:0] {IDLE, CALC, DONE} MulDivState;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M shift-add multiplier / restoring divider; MULDIV_EARLY_OUT_EN enables 1-cycle trivial ops
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [3:0]            func_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] y_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    function automatic logic [W-1:0] f_neg(input logic [W-1:0] x, input logic s);
        return s ? -x : x;
    endfunction

    MulDivState      r_state, w_next;
    MulDiv_Ops       r_op, w_op;
    logic [CW-1:0]   r_cnt;
    logic            r_neg, r_spec;
    logic [W-1:0]    r_spec_y, r_md, r_y;
    logic [2*W-1:0]  r_acc;

    logic            w_accept, w_last, w_fast, w_rdiv;
    logic            w_sa, w_sb, w_neg, w_dz, w_ov, w_spec;
    logic [W-1:0]    w_a_abs, w_b_abs, w_spec_y, w_q, w_r, w_fin;
    logic [W:0]      w_sum;
    logic [2*W-1:0]  w_acc_nxt, w_prod;

    // Undefined encodings fall back to a plain low-half multiply.
    assign w_op     = func_op_i[3] ? MulOp : MulDiv_Ops'(func_op_i);
    assign w_accept = start_i && r_state != CALC;
    assign w_last   = r_cnt == CW'(1);

    assign w_sa     = a_i[W-1] && (w_op inside {MulhOp, MulhsuOp, DivOp, RemOp});
    assign w_sb     = b_i[W-1] && (w_op inside {MulhOp, DivOp, RemOp});
    assign w_a_abs  = f_neg(a_i, w_sa);
    assign w_b_abs  = f_neg(b_i, w_sb);
    // Remainder follows the dividend's sign; everything else takes the XOR.
    assign w_neg    = (w_op == RemOp) ? w_sa : w_sa ^ w_sb;

    assign w_dz     = b_i == '0;
    assign w_ov     = a_i == {1'b1, {(W-1){1'b0}}} && b_i == '1;
    assign w_spec   = (w_op inside {DivOp, DivuOp, RemOp, RemuOp}) &&
                      (w_dz || ((w_op inside {DivOp, RemOp}) && w_ov));
    assign w_spec_y = w_dz ? ((w_op inside {DivOp, DivuOp}) ? '1 : a_i)
                           : ((w_op == DivOp) ? a_i : '0);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_fast = w_spec || (!(w_op inside {DivOp, DivuOp, RemOp, RemuOp}) && (a_i == '0 || b_i == '0));
`else
    assign w_fast = 1'b0;
`endif

    // One W+1-bit adder serves both the multiply accumulate and the divide trial subtract.
    assign w_rdiv    = r_op inside {DivOp, DivuOp, RemOp, RemuOp};
    assign w_sum     = w_rdiv ? (r_acc[2*W-1:W-1] - {1'b0, r_md})
                              : ({1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_md} : '0));
    assign w_acc_nxt = w_rdiv ? (w_sum[W] ? {r_acc[2*W-2:0], 1'b0} : {w_sum[W-1:0], r_acc[W-2:0], 1'b1})
                              : {w_sum, r_acc[W-1:1]};

    assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_q    = f_neg(w_acc_nxt[W-1:0], r_neg);
    assign w_r    = f_neg(w_acc_nxt[2*W-1:W], r_neg);
    assign w_fin  = r_spec ? r_spec_y
                  : !w_rdiv ? ((r_op == MulOp) ? w_prod[W-1:0] : w_prod[2*W-1:W])
                  : (r_op inside {DivOp, DivuOp}) ? w_q : w_r;

    assign busy_o = r_state == CALC;
    assign done_o = r_state == DONE;
    assign y_o    = r_y;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state: CALC runs until the counter reaches 1; DONE lasts one cycle unless re-started.
    always_comb begin
        w_next = r_state;
        if (r_state == CALC) w_next = w_last ? DONE : CALC;
        else                 w_next = start_i ? (w_fast ? DONE : CALC) : IDLE;
    end

    // Operand latch on accept, one shift/add-or-subtract step per CALC cycle, result on exit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_op     <= MulOp;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_spec   <= 1'b0;
            r_spec_y <= '0;
            r_md     <= '0;
            r_acc    <= '0;
            r_y      <= '0;
        end else if (w_accept) begin
            r_op     <= w_op;
            r_cnt    <= CW'(W);
            r_neg    <= w_neg;
            r_spec   <= w_spec;
            r_spec_y <= w_spec_y;
            r_md     <= w_op[2] ? w_b_abs : w_a_abs;
            r_acc    <= {{W{1'b0}}, w_op[2] ? w_a_abs : w_b_abs};
            if (w_fast) r_y <= w_spec ? w_spec_y : '0;
        end else if (r_state == CALC) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) r_y <= w_fin;
        end
    end

`ifdef SIMULATE
    // Flag undefined opcodes in simulation.
    always_ff @(posedge clk_i) begin
        if (w_accept && func_op_i[3]) $display("muldiv_unit: undefined func_op %0d treated as MulOp", func_op_i);
    end
`endif

endmodule
